// File: rtl/multiplicador_8bits_seq_if.sv
// Operand/result bundle for the sequential 8x8 multiplier.
// master drives operands and start; slave returns product and status.
interface multiplicador_8bits_seq_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Produto;
    logic        Overflow;
    logic        Zero;
    logic        busy;
    logic        done;

    modport master (
        output start, A, B,
        input  Produto, Overflow, Zero, busy, done
    );

    modport slave (
        input  start, A, B,
        output Produto, Overflow, Zero, busy, done
    );
endinterface

// File: rtl/multiplicador_8bits_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product.
// One multiplier bit per clock, fixed 8-cycle latency, one-cycle done.
module multiplicador_8bits_seq (
    input  logic                            clk,
    input  logic                            rst,
    multiplicador_8bits_seq_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand;
    logic [16:0] acc;
    logic [3:0]  cnt;
    logic [15:0] produto;
    logic        overflow;
    logic        zero;
    logic [8:0]  upper_sum;
    logic [16:0] shifted;

    // 9-bit add keeps the carry, which lands in bit 15 after the shift
    always_comb begin
        upper_sum = acc[16:8];
        if (acc[0]) begin
            upper_sum = acc[16:8] + {1'b0, mcand};
        end
        shifted = {1'b0, upper_sum, acc[7:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = CALC;
            CALC: if (cnt == 4'd7) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            produto  <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.A;
                        acc   <= {9'b0, bus.B};
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= shifted;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        produto  <= shifted[15:0];
                        overflow <= |shifted[15:8];
                        zero     <= ~|shifted[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Produto  = produto;
    assign bus.Overflow = overflow;
    assign bus.Zero     = zero;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_multiplicador_8bits_seq.sv
// Directed bench for multiplicador_8bits_seq: latency, flags,
// busy-start rejection, asynchronous reset and a random sweep.
module tb_multiplicador_8bits_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multiplicador_8bits_seq_if bus ();

    multiplicador_8bits_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start at E0, expect done after exactly E8, idle after E9
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        logic [15:0] prev;
        int lat;
        prod = 16'(a) * 16'(b);
        prev = bus.Produto;
        lat = 0;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_e0", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 4) chk("produto_stable", 32'(bus.Produto), 32'(prev));
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, 8);
        chk("produto", 32'(bus.Produto), 32'(prod));
        chk("overflow", 32'(bus.Overflow), 32'(prod > 16'd255));
        chk("zero", 32'(bus.Zero), 32'(prod == 16'd0));
        step();
        chk("done_low_e9", 32'(bus.done), 32'd0);
        chk("busy_low_e9", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int seen_done;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #12;
        chk("rst_produto", 32'(bus.Produto), 32'd0);
        chk("rst_overflow", 32'(bus.Overflow), 32'd0);
        chk("rst_zero", 32'(bus.Zero), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        run_mul(8'd13, 8'd11);
        chk("p13x11", 32'(bus.Produto), 32'h008F);
        run_mul(8'd255, 8'd255);
        chk("p255x255", 32'(bus.Produto), 32'hFE01);
        chk("ovf255", 32'(bus.Overflow), 32'd1);
        run_mul(8'd0, 8'd200);
        chk("zero0x200", 32'(bus.Zero), 32'd1);

        // start while busy: pulses at E4 and E9 must be ignored
        bus.A = 8'd16;
        bus.B = 8'd16;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        bus.A = 8'd3;
        bus.B = 8'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        step();
        chk("busy_ign_done", 32'(bus.done), 32'd1);
        chk("busy_ign_prod", 32'(bus.Produto), 32'h0100);
        chk("busy_ign_ovf", 32'(bus.Overflow), 32'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("e9_ign_busy", 32'(bus.busy), 32'd0);
        chk("e9_ign_prod", 32'(bus.Produto), 32'h0100);
        run_mul(8'd3, 8'd3);
        chk("p3x3", 32'(bus.Produto), 32'd9);

        // asynchronous reset in the middle of a computation
        run_mul(8'd200, 8'd2);
        chk("p200x2", 32'(bus.Produto), 32'd400);
        bus.A = 8'd7;
        bus.B = 8'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_produto", 32'(bus.Produto), 32'd0);
        chk("arst_overflow", 32'(bus.Overflow), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        step();
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) seen_done = 1;
        end
        chk("arst_no_done", seen_done, 0);
        run_mul(8'd7, 8'd7);
        chk("p7x7", 32'(bus.Produto), 32'd49);

        for (int i = 0; i < 20; i++) begin
            run_mul(8'($urandom_range(255)), 8'($urandom_range(255)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
